// File: rtl/keypad_scanner_if.sv
// -----------------------------------------------------------------------------
// keypad_scanner_if
// Bundles the keypad matrix lines and the decoded-key / digit-entry outputs of
// keypad_scanner.
//   rows       keypad row lines, active-low, rows[0] = top row
//   cols       keypad column drive, active-low one-hot, cols[0] = left column
//   key_code   code of the last accepted key
//   key_valid  one-cycle pulse when a press is accepted
//   entry_done one-cycle pulse after '#'
//   bcd0..2    entered digits, bcd0 least significant
// master: the scanner side. slave: keypad plus display/consumer side.
// -----------------------------------------------------------------------------
interface keypad_scanner_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       entry_done;
    logic [3:0] bcd0;
    logic [3:0] bcd1;
    logic [3:0] bcd2;

    modport master (
        input  rows,
        output cols, key_code, key_valid, entry_done, bcd0, bcd1, bcd2
    );

    modport slave (
        output rows,
        input  cols, key_code, key_valid, entry_done, bcd0, bcd1, bcd2
    );
endinterface

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column per SCAN_DIV clocks,
// classifies each full scan as no key / one key / several keys, debounces the
// scan results and decodes accepted presses. Numeric keys shift into a
// 3-digit BCD entry register, '*' clears it, '#' pulses entry_done.
// Ports:
//   clk    system clock
//   reset  synchronous, active-low reset
//   kp     keypad_scanner_if.master (rows in; cols, key_code, key_valid,
//          entry_done, bcd0..2 out)
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic               clk,
    input  logic               reset,
    keypad_scanner_if.master   kp
);
    localparam int              DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      STABLE_MAX = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_kind_t;
    typedef enum logic {IDLE, HELD} state_t;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_q;
    logic [1:0]       hit_cnt_q;     // low contacts seen this scan, saturates at 2
    logic [3:0]       hit_code_q;    // code of the single contact seen so far
    res_kind_t        prev_kind_q;
    logic [3:0]       prev_code_q;
    logic [3:0]       stable_q;
    state_t           state_q, state_d;
    logic [3:0]       key_code_q;
    logic             key_valid_q;
    logic             entry_done_q;
    logic [3:0]       bcd0_q, bcd1_q, bcd2_q;

    logic             tick, scan_done, accept;
    logic [3:0]       row_hits;
    logic [2:0]       row_cnt;
    logic [1:0]       row_idx;
    logic [2:0]       acc_sum;
    logic [1:0]       acc_cnt;
    logic [3:0]       acc_code;
    res_kind_t        res_kind;
    logic [3:0]       res_code;
    logic [3:0]       stable_nxt;

    assign tick      = (div_q == DIV_LAST);
    assign scan_done = tick && (col_q == 2'd3);
    assign kp.cols   = ~(4'b0001 << col_q);

    // Per-column sample folded into the running scan; column 0 starts a new scan.
    always_comb begin
        row_hits = ~kp.rows;
        row_cnt  = 3'($countones(row_hits));
        row_idx  = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (row_hits[r]) row_idx = 2'(r);
        end
        acc_sum  = ((col_q == 2'd0) ? 3'd0 : {1'b0, hit_cnt_q}) + row_cnt;
        acc_cnt  = (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
        acc_code = (row_cnt == 3'd1) ? key_map(row_idx, col_q)
                                     : ((col_q == 2'd0) ? 4'h0 : hit_code_q);
        case (acc_cnt)
            2'd0:    res_kind = RES_NONE;
            2'd1:    res_kind = RES_KEY;
            default: res_kind = RES_MULTI;
        endcase
        // Non-key results carry code 0 so equality compares kind alone.
        res_code   = (res_kind == RES_KEY) ? acc_code : 4'h0;
        stable_nxt = ((res_kind == prev_kind_q) && (res_code == prev_code_q))
                   ? ((stable_q >= STABLE_MAX) ? STABLE_MAX : stable_q + 4'd1)
                   : 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q       <= '0;
            col_q       <= 2'd0;
            hit_cnt_q   <= 2'd0;
            hit_code_q  <= 4'h0;
            prev_kind_q <= RES_NONE;
            prev_code_q <= 4'h0;
            stable_q    <= 4'd0;
        end else if (tick) begin
            div_q      <= '0;
            col_q      <= col_q + 2'd1;
            hit_cnt_q  <= acc_cnt;
            hit_code_q <= acc_code;
            if (scan_done) begin
                prev_kind_q <= res_kind;
                prev_code_q <= res_code;
                stable_q    <= stable_nxt;
            end
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Debounce FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Debounce FSM: next state
    always_comb begin
        state_d = state_q;
        if (scan_done && (stable_nxt == STABLE_MAX)) begin
            case (state_q)
                IDLE:    if (res_kind == RES_KEY)  state_d = HELD;
                default: if (res_kind == RES_NONE) state_d = IDLE;
            endcase
        end
    end

    // Debounce FSM: output decode
    always_comb begin
        accept = (state_q == IDLE) && scan_done && (res_kind == RES_KEY)
                 && (stable_nxt == STABLE_MAX);
    end

    // Key register and entry register; the entry register reacts one cycle
    // after key_valid, using the already-registered key_code.
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_code_q   <= 4'h0;
            key_valid_q  <= 1'b0;
            entry_done_q <= 1'b0;
            bcd0_q       <= 4'h0;
            bcd1_q       <= 4'h0;
            bcd2_q       <= 4'h0;
        end else begin
            key_valid_q  <= accept;
            if (accept) key_code_q <= res_code;
            entry_done_q <= key_valid_q && (key_code_q == 4'hF);
            if (key_valid_q) begin
                if (key_code_q <= 4'd9) begin
                    bcd2_q <= bcd1_q;
                    bcd1_q <= bcd0_q;
                    bcd0_q <= key_code_q;
                end else if (key_code_q == 4'hE) begin
                    bcd2_q <= 4'h0;
                    bcd1_q <= 4'h0;
                    bcd0_q <= 4'h0;
                end
            end
        end
    end

    assign kp.key_code   = key_code_q;
    assign kp.key_valid  = key_valid_q;
    assign kp.entry_done = entry_done_q;
    assign kp.bcd0       = bcd0_q;
    assign kp.bcd1       = bcd1_q;
    assign kp.bcd2       = bcd2_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Directed scenarios plus a randomized phase for keypad_scanner with
// SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle scans). A behavioural model follows
// the keypad rules (per-scan contact list, run length of identical results,
// digit shift register) and every cycle's outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;
    localparam int SD  = 4;
    localparam int DEB = 2;
    localparam int SCAN = 4 * SD;

    logic        clk;
    logic        reset_n;
    logic [15:0] pressed;      // bit r*4+c = contact (row r, col c) closed
    int          n_cmp;
    int          n_fail;
    bit          chk_en;
    int          pulses;
    int          dones;

    keypad_scanner_if kp ();

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB)) dut (
        .clk   (clk),
        .reset (reset_n),
        .kp    (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive keypad: a closed contact pulls its row low while its column is driven.
    always_comb begin
        kp.rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp.cols[c]) kp.rows[r] = 1'b0;
    end

    // ---------------- behavioural model ----------------
    int keymap [16];
    int m_div, m_col, m_nhits, m_hcode;
    int m_code, m_bcd0, m_bcd1, m_bcd2;
    bit m_valid, m_done, m_held;
    int res_hist [$];           // -1 = no key, -2 = several keys, else key code

    initial begin
        keymap = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_div = 0; m_col = 0; m_nhits = 0; m_hcode = 0;
                m_code = 0; m_valid = 0; m_done = 0; m_held = 0;
                m_bcd0 = 0; m_bcd1 = 0; m_bcd2 = 0;
                res_hist.delete();
            end else begin
                m_done = m_valid && (m_code == 15);
                if (m_valid && m_code <= 9) begin
                    m_bcd2 = m_bcd1; m_bcd1 = m_bcd0; m_bcd0 = m_code;
                end else if (m_valid && m_code == 14) begin
                    m_bcd2 = 0; m_bcd1 = 0; m_bcd0 = 0;
                end
                m_valid = 0;
                if (m_div == SD - 1) begin
                    if (m_col == 0) m_nhits = 0;
                    for (int r = 0; r < 4; r++)
                        if (pressed[r*4+m_col]) begin
                            m_nhits++;
                            m_hcode = keymap[r*4+m_col];
                        end
                    if (m_col == 3) begin
                        int res, run;
                        res = (m_nhits == 0) ? -1 : (m_nhits == 1) ? m_hcode : -2;
                        res_hist.push_back(res);
                        run = 0;
                        for (int i = res_hist.size() - 1; i >= 0; i--) begin
                            if (res_hist[i] != res) break;
                            run++;
                        end
                        if (!m_held && res >= 0 && run >= DEB) begin
                            m_held = 1; m_code = res; m_valid = 1;
                        end else if (m_held && res == -1 && run >= DEB) begin
                            m_held = 0;
                        end
                    end
                    m_col = (m_col + 1) % 4;
                    m_div = 0;
                end else begin
                    m_div++;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        logic [3:0]  ecols;
        logic [21:0] exp_v, act_v;
        ecols = ~(4'b0001 << m_col);
        exp_v = {ecols, m_valid, 4'(m_code), m_done, 4'(m_bcd2), 4'(m_bcd1), 4'(m_bcd0)};
        act_v = {kp.cols, kp.key_valid, kp.key_code, kp.entry_done, kp.bcd2, kp.bcd1, kp.bcd0};
        n_cmp++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_outputs t=%0t dut={cols,kv,code,done,bcd}=%h model=%h",
                     $time, act_v, exp_v);
        end
    endtask

    // One clock: compare on the falling edge, then return just after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (chk_en) begin
                cmp_cycle();
                if (kp.key_valid === 1'b1)  pulses++;
                if (kp.entry_done === 1'b1) dones++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scans(input int n);
        step(n * SCAN);
    endtask

    task automatic tap(input int idx);
        pressed = 16'h0;
        pressed[idx] = 1'b1;
        scans(3);
        pressed = 16'h0;
        scans(3);
    endtask

    initial begin
        int p0, d0;
        logic [3:0] col_seq [4];
        n_cmp = 0; n_fail = 0; chk_en = 0; pulses = 0; dones = 0;
        reset_n = 1'b0;
        pressed = 16'h0;
        col_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

        // 1: reset and column stepping
        @(posedge clk); #1;
        chk_en = 1;
        step(4);
        check("reset_cols", int'(kp.cols), 4'b1110);
        check("reset_bcd", int'({kp.bcd2, kp.bcd1, kp.bcd0}), 0);
        check("reset_key_valid", int'(kp.key_valid), 0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(SD);
            check("col_step", int'(kp.cols), int'(col_seq[i]));
        end

        // 2: hold '5' for 10 scans
        p0 = pulses;
        pressed = 16'h0; pressed[5] = 1'b1;
        scans(10);
        check("key5_pulses", pulses - p0, 1);
        check("key5_code", int'(kp.key_code), 5);
        check("key5_model_code", m_code, 5);
        check("key5_bcd0", int'(kp.bcd0), 5);
        pressed = 16'h0;
        scans(3);

        // 3: keys 1,2,3,4
        p0 = pulses;
        tap(0); tap(1); tap(2); tap(4);
        check("seq_pulses", pulses - p0, 4);
        check("seq_digits", int'({kp.bcd2, kp.bcd1, kp.bcd0}), 12'h234);

        // 4: bouncing '7', then stable
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            pressed = 16'h0;
            if (i % 2 == 0) pressed[8] = 1'b1;
            scans(1);
        end
        check("bounce_no_pulse", pulses - p0, 0);
        tap(8);
        check("bounce_then_stable", pulses - p0, 1);
        check("key7_code", int'(kp.key_code), 7);
        check("key7_digits", int'({kp.bcd2, kp.bcd1, kp.bcd0}), 12'h347);

        // 5: two keys at once, '*', digit, '#'
        p0 = pulses;
        pressed = 16'h0003;
        scans(5);
        check("multi_no_pulse", pulses - p0, 0);
        pressed = 16'h0;
        scans(3);
        tap(12);
        check("star_clears", int'({kp.bcd2, kp.bcd1, kp.bcd0}), 0);
        tap(6);
        check("digit6", int'({kp.bcd2, kp.bcd1, kp.bcd0}), 12'h006);
        d0 = dones;
        tap(14);
        check("hash_code", int'(kp.key_code), 15);
        check("hash_done_once", dones - d0, 1);
        check("hash_digits_kept", int'({kp.bcd2, kp.bcd1, kp.bcd0}), 12'h006);

        // 6: reset while '9' held, then re-accept
        p0 = pulses;
        pressed = 16'h0; pressed[10] = 1'b1;
        scans(3);
        check("key9_pulse", pulses - p0, 1);
        reset_n = 1'b0;
        step(3);
        check("midpress_reset_outs",
              int'({kp.cols, kp.key_valid, kp.key_code, kp.entry_done, kp.bcd2, kp.bcd1, kp.bcd0}),
              int'({4'b1110, 18'h0}));
        reset_n = 1'b1;
        p0 = pulses;
        scans(3);
        check("key9_after_reset", pulses - p0, 1);
        check("key9_digits", int'({kp.bcd2, kp.bcd1, kp.bcd0}), 12'h009);
        pressed = 16'h0;
        scans(3);

        // randomized phase: arbitrary timing, single/multi presses, short resets
        for (int it = 0; it < 60; it++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            pressed = 16'h0;
            if (kind >= 3 && kind <= 7) begin
                pressed[$urandom_range(0, 15)] = 1'b1;
            end else if (kind == 8) begin
                pressed[$urandom_range(0, 15)] = 1'b1;
                pressed[$urandom_range(0, 15)] = 1'b1;
            end else if (kind == 9) begin
                reset_n = 1'b0;
                step(int'($urandom_range(1, 3)));
                reset_n = 1'b1;
            end
            step(int'($urandom_range(4, 70)));
        end
        pressed = 16'h0;
        scans(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
